// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and types shared by the architectural register file
// and its write decoder.
//   NUM_REGS   - register count, including the hardwired zero register
//   REG_ADDR_W - width of a register index
//   ZERO_REG   - index of XZR, which always reads 0 and ignores writes
//   reg_addr_t - register index type
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/mux32_1.sv
// mux32_1: shared 32:1 single-bit read multiplexer cell used by the datapath.
// Ports:
//   in  [31:0] - candidate bits, in[k] selected when sel == k
//   sel [4:0]  - select index
//   out        - selected bit
module mux32_1 (
  input  logic [31:0] in,
  input  logic [4:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/regfile_decoder.sv
// decoder5_32: 5-to-32 one-hot write-enable decoder gated by an enable.
// Ports:
//   idx    - register index to decode
//   en     - gate; all outputs 0 when low
//   onehot - one-hot enable, bit idx set when en is high
import regfile_pkg::*;

module decoder5_32 (
  input  reg_addr_t             idx,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x WIDTH architectural register file, one synchronous write
// port, two combinational read ports. Register 31 (XZR) has no storage and
// always reads 0. Each read-port bit is driven by its own mux32_1 fed with
// that bit of all 32 registers.
// Parameters:
//   WIDTH - data width (default 64)
// Ports:
//   clk           - system clock, rising-edge writes
//   reset_n       - asynchronous active-low clear of all registers
//   RegWrite      - write enable
//   WriteRegister - destination index
//   WriteData     - data to write
//   ReadRegister1 - read port 1 index
//   ReadRegister2 - read port 2 index
//   ReadData1     - contents of ReadRegister1
//   ReadData2     - contents of ReadRegister2
// Build option:
//   REGFILE_BYPASS_EN - when defined, a read of the register being written
//   in the same cycle returns WriteData combinationally (never for XZR, and
//   never while reset is asserted).
import regfile_pkg::*;

module regfile #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWrite,
  input  reg_addr_t        WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  reg_addr_t        ReadRegister1,
  input  reg_addr_t        ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [NUM_REGS-1:0] we;
  logic                unused_we31;
  logic [WIDTH-1:0]    regs [NUM_REGS-1];
  logic [NUM_REGS-1:0] bit_slice [WIDTH];
  logic [WIDTH-1:0]    mux_rd1;
  logic [WIDTH-1:0]    mux_rd2;

  decoder5_32 u_dec (
    .idx    (WriteRegister),
    .en     (RegWrite),
    .onehot (we)
  );

  // XZR has no storage, so its decoded enable goes nowhere.
  assign unused_we31 = we[NUM_REGS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS-1; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS-1; r++)
        if (we[r]) regs[r] <= WriteData;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar r = 0; r < NUM_REGS-1; r++) begin : g_reg
      assign bit_slice[b][r] = regs[r][b];
    end
    assign bit_slice[b][NUM_REGS-1] = 1'b0;

    mux32_1 u_mux_rd1 (
      .in  (bit_slice[b]),
      .sel (ReadRegister1),
      .out (mux_rd1[b])
    );

    mux32_1 u_mux_rd2 (
      .in  (bit_slice[b]),
      .sel (ReadRegister2),
      .out (mux_rd2[b])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;

  // Forwarding is held off during reset so outputs stay 0 while cleared.
  assign byp_ok    = reset_n && RegWrite && (WriteRegister != ZERO_REG);
  assign ReadData1 = (byp_ok && (ReadRegister1 == WriteRegister)) ? WriteData : mux_rd1;
  assign ReadData2 = (byp_ok && (ReadRegister2 == WriteRegister)) ? WriteData : mux_rd2;
`else
  assign ReadData1 = mux_rd1;
  assign ReadData2 = mux_rd2;
`endif

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
  import regfile_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] BASE = 64'h0123_4567_89AB_0000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         RegWrite;
  reg_addr_t    WriteRegister;
  logic [W-1:0] WriteData;
  reg_addr_t    ReadRegister1;
  reg_addr_t    ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  logic [W-1:0] sb [$];
  int total = 0;
  int bad   = 0;

  regfile #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  // at_neg: step to the next falling edge before setting the read index,
  // keeping the sample well away from the rising edge.
  task automatic chk(input string tag, input int port, input int addr,
                     input logic [W-1:0] exp, input bit at_neg);
    logic [W-1:0] e;
    logic [W-1:0] obs;
    if (at_neg) @(negedge clk);
    if (port == 2) ReadRegister2 = reg_addr_t'(addr);
    else           ReadRegister1 = reg_addr_t'(addr);
    sb.push_back(exp);
    #1;
    e   = sb.pop_front();
    obs = (port == 2) ? ReadData2 : ReadData1;
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s port%0d idx%0d: observed=%h expected=%h", tag, port, addr, obs, e);
    end
  endtask

  task automatic wr(input int addr, input logic [W-1:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = reg_addr_t'(addr);
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = '1;
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // Reset held with a write request pending: everything reads 0.
    for (int i = 0; i < NUM_REGS; i++) chk("reset_sweep", 1, i, '0, 1'b1);
    chk("reset_rd2", 2, 3, '0, 1'b1);

    // Write coinciding with the first edge after release is performed.
    @(negedge clk);
    reset_n       = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd2;
    WriteData     = 64'h5A5A;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("release_write", 1, 2, 64'h5A5A, 1'b1);

    // Fill every stored register, then read back on both ports in opposite order.
    for (int i = 0; i < NUM_REGS-1; i++) wr(i, BASE + 64'(i));
    for (int i = 0; i < NUM_REGS-1; i++) begin
      chk("readback1", 1, i, BASE + 64'(i), 1'b1);
      chk("readback2", 2, 30 - i, BASE + 64'(30 - i), 1'b0);
    end

    // XZR ignores writes.
    wr(31, '1);
    chk("xzr_rd1", 1, 31, '0, 1'b1);
    chk("xzr_rd2", 2, 31, '0, 1'b0);
    chk("x30_after_xzr", 1, 30, BASE + 64'd30, 1'b1);

    // Write disabled: X5 holds.
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd5;
    WriteData     = 64'hDEAD;
    @(posedge clk);
    chk("we_off_x5", 1, 5, BASE + 64'd5, 1'b1);

    // Same-cycle read of the register being written.
    wr(7, 64'h1);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'h2;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_x7", 1, 7, 64'h2, 1'b0);
`else
    chk("same_cycle_x7", 1, 7, 64'h1, 1'b0);
`endif
    chk("same_cycle_other", 2, 8, BASE + 64'd8, 1'b0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("after_edge_x7", 1, 7, 64'h2, 1'b1);

    // A pending XZR write never forwards.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = '1;
    chk("xzr_no_bypass", 1, 31, '0, 1'b0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("xzr_after", 2, 31, '0, 1'b1);

    // Mid-run reset clears immediately, between clock edges.
    wr(3, 64'hAA);
    chk("x3_loaded", 2, 3, 64'hAA, 1'b1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    chk("midreset_async", 2, 3, '0, 1'b0);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h55;
    @(posedge clk);
    chk("midreset_write_blocked", 2, 3, '0, 1'b1);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    reset_n = 1'b1;
    chk("post_reset_x3", 2, 3, '0, 1'b1);
    chk("post_reset_x7", 1, 7, '0, 1'b0);
    chk("post_reset_x30", 1, 30, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
